alu_cmd_issuer: RTL and testbench

//  Command-side master for the combinational ALU (A_bus/B_bus/op -> C_bus/Z).

---
 rtl/alu_cmd_issuer.sv | 197 +++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Issues one ALU command at a time, holds the operand buses for a settle window and
// queues {result, zero, error} in a small response FIFO. Optional ALU_STATS_EN adds stat_cnt.
module alu_cmd_issuer #(
  parameter int DATA_W     = 32,
  parameter int SETTLE_CYC = 1,
  parameter int RSP_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] A_bus,
  output logic [DATA_W-1:0] B_bus,
  output logic [2:0]        op,
  input  logic [DATA_W-1:0] C_bus,
  input  logic              Z,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_z,
  output logic              rsp_err
`ifdef ALU_STATS_EN
  ,
  output logic [15:0]       stat_cnt
`endif
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_ERR} state_t;

  state_t            state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic              ready_q, ready_d;

  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_data [RSP_DEPTH];
  logic              mem_z    [RSP_DEPTH];
  logic              mem_err  [RSP_DEPTH];
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic              head_z_q, head_z_d, head_err_q, head_err_d;

  logic              accept, illegal, push, pop;
  logic [DATA_W-1:0] push_data;
  logic              push_z, push_err;

  assign cmd_ready = ready_q;
  assign accept    = cmd_valid && ready_q;
  assign A_bus     = a_q;
  assign B_bus     = b_q;
  assign op        = op_q;
  assign rsp_valid = (count_q != '0);
  assign rsp_data  = head_data_q;
  assign rsp_z     = head_z_q;
  assign rsp_err   = head_err_q;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    illegal = 1'b1;
    case (cmd_op)
      3'b001, 3'b010, 3'b011: illegal = 1'b0;
      3'b100, 3'b101:         illegal = (cmd_b == '0);
      default:                illegal = 1'b1;
    endcase
  end

  assign push      = ((state_q == ST_DRIVE) && (settle_q == '0)) || (state_q == ST_ERR);
  assign push_err  = (state_q == ST_ERR);
  assign push_data = push_err ? '0 : C_bus;
  assign push_z    = push_err ? 1'b0 : Z;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (illegal) begin
            state_d = ST_ERR;
          end else begin
            state_d  = ST_DRIVE;
            settle_d = SET_W'(SETTLE_CYC - 1);
            a_d      = cmd_a;
            b_d      = cmd_b;
            op_d     = cmd_op;
          end
        end
      end
      ST_DRIVE: begin
        if (settle_q == '0) begin
          state_d = ST_IDLE;
          a_d     = '0;
          b_d     = '0;
          op_d    = 3'b000;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ready_d = (state_d == ST_IDLE) && (count_d < CNT_W'(RSP_DEPTH));
  end

  // Head register: holds the last popped entry once the FIFO drains.
  always_comb begin
    head_data_d = head_data_q;
    head_z_d    = head_z_q;
    head_err_d  = head_err_q;
    if (count_d != '0) begin
      if (push && (rd_d == wr_q)) begin
        head_data_d = push_data;
        head_z_d    = push_z;
        head_err_d  = push_err;
      end else begin
        head_data_d = mem_data[rd_d];
        head_z_d    = mem_z[rd_d];
        head_err_d  = mem_err[rd_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_q] <= push_data;
      mem_z[wr_q]    <= push_z;
      mem_err[wr_q]  <= push_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 3'b000;
      ready_q     <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      head_data_q <= '0;
      head_z_q    <= 1'b0;
      head_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      ready_q     <= ready_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_z_q    <= head_z_d;
      head_err_q  <= head_err_d;
    end
  end

`ifdef ALU_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (push && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer with a behavioural ALU; expected responses are queued at
// command acceptance and checked by an independent response monitor.
module tb_alu_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'b000;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic [31:0] A_bus, B_bus, C_bus;
  logic [2:0]  op;
  logic        Z;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_z, rsp_err;
`ifdef ALU_STATS_EN
  logic [15:0] stat_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] d;
    logic        z;
    logic        e;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    C_bus = '0;
    case (op)
      3'b001: C_bus = A_bus + B_bus;
      3'b010: C_bus = A_bus - B_bus;
      3'b011: C_bus = A_bus * B_bus;
      3'b100: C_bus = (B_bus != 0) ? A_bus / B_bus : '0;
      3'b101: C_bus = (B_bus != 0) ? A_bus % B_bus : '0;
      default: C_bus = '0;
    endcase
  end
  assign Z = (C_bus == '0);

  alu_cmd_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .A_bus(A_bus), .B_bus(B_bus), .op(op), .C_bus(C_bus), .Z(Z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_z(rsp_z), .rsp_err(rsp_err)
`ifdef ALU_STATS_EN
    , .stat_cnt(stat_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got data %0h err %0b with nothing expected", rsp_data, rsp_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.d);
        check("rsp_z", {31'd0, rsp_z}, {31'd0, e.z});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.e});
        if (e.cyc >= 0) check("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ed, input logic ez, input logic ee, input bit lat);
    int n;
    exp_t e;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = o; cmd_a = a; cmd_b = b;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: cmd_ready stayed %0b, required 1", cmd_ready);
    end else begin
      e.d = ed; e.z = ez; e.e = ee;
      e.cyc = lat ? cyc + 2 : -1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 3'b000; cmd_a = '0; cmd_b = '0;
    @(negedge clk);
    if (ee) begin
      check("err_A_bus", A_bus, 32'd0);
      check("err_B_bus", B_bus, 32'd0);
      check("err_op", {29'd0, op}, 32'd0);
    end else begin
      check("drive_A_bus", A_bus, a);
      check("drive_B_bus", B_bus, b);
      check("drive_op", {29'd0, op}, {29'd0, o});
    end
    check("busy_ready", {31'd0, cmd_ready}, 32'd0);
  endtask

  initial begin
    #12;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_A_bus", A_bus, 32'd0);
    check("rst_op", {29'd0, op}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    #3 rst_n = 1'b1;

    send(3'b001, 32'd10, 32'd6, 32'd16, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("empty_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("hold_last_data", rsp_data, 32'd16);

    send(3'b010, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0, 1'b1);
    send(3'b010, 32'd6, 32'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);

    send(3'b011, 32'd8, 32'd7, 32'd56, 1'b0, 1'b0, 1'b1);
    send(3'b100, 32'd17, 32'd5, 32'd3, 1'b0, 1'b0, 1'b1);
    send(3'b101, 32'd17, 32'd5, 32'd2, 1'b0, 1'b0, 1'b1);

    send(3'b100, 32'd17, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    send(3'b111, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);

    // Backpressure: two responses fill the FIFO, the third waits for one pop.
    rsp_ready = 1'b0;
    send(3'b001, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
    send(3'b001, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("full_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("stall_head_data", rsp_data, 32'd3);
    fork
      send(3'b001, 32'd5, 32'd6, 32'd11, 1'b0, 1'b0, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check("refill_head_data", rsp_data, 32'd7);
    @(posedge clk); #1 rsp_ready = 1'b1;
    repeat (4) @(posedge clk);

    // Reset while the buses are driven: command must vanish.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 3'b001; cmd_a = 32'd2; cmd_b = 32'd2;
    @(negedge clk);
    check("pre_rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 3'b000; cmd_a = '0; cmd_b = '0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_A_bus", A_bus, 32'd0);
    check("midrst_op", {29'd0, op}, 32'd0);
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
`ifdef ALU_STATS_EN
    check("midrst_stat_cnt", {16'd0, stat_cnt}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
